hdmi_video_timing: RTL and testbench

HDMI_VIDEO_TIMING -- requirements
Module: hdmi_video_timing

---
 rtl/hdmi_video_timing.sv | 169 ++++++++++++++++
 tb/tb_hdmi_video_timing.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_video_timing.sv
// hdmi_video_timing
// Video timing generator for an HDMI transmitter (default 1280x720p60,
// 74.25 MHz pixel clock). Produces line/frame counters and the matching
// sync, data-enable and frame-start strobes. Counting only runs while the
// PLL lock indication, synchronised into clk, is high; losing lock drops
// the generator back to IDLE and relock always restarts a clean frame.
//
// Ports
//   clk         : pixel clock (only clock)
//   rst_n       : asynchronous active-low reset
//   pll_locked  : asynchronous PLL lock flag
//   hs, vs      : horizontal / vertical sync, active level set by H_POL/V_POL
//   de          : data enable, high during active video
//   hcnt, vcnt  : pixel index in the line / line index in the frame
//   frame_start : one-cycle pulse at pixel (0,0)
//   running     : generator is in RUN
module hdmi_video_timing #(
  parameter int   H_ACT  = 1280,
  parameter int   H_FP   = 110,
  parameter int   H_SYNC = 40,
  parameter int   H_BP   = 220,
  parameter int   V_ACT  = 720,
  parameter int   V_FP   = 5,
  parameter int   V_SYNC = 5,
  parameter int   V_BP   = 20,
  parameter logic H_POL  = 1'b1,
  parameter logic V_POL  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pll_locked,
  output logic        hs,
  output logic        vs,
  output logic        de,
  output logic [11:0] hcnt,
  output logic [11:0] vcnt,
  output logic        frame_start,
  output logic        running
);

  localparam logic [11:0] HTOT     = 12'(H_ACT + H_FP + H_SYNC + H_BP);
  localparam logic [11:0] VTOT     = 12'(V_ACT + V_FP + V_SYNC + V_BP);
  localparam logic [11:0] H_ACT_W  = 12'(H_ACT);
  localparam logic [11:0] V_ACT_W  = 12'(V_ACT);
  localparam logic [11:0] HS_START = 12'(H_ACT + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACT + H_FP + H_SYNC);
  localparam logic [11:0] VS_START = 12'(V_ACT + V_FP);
  localparam logic [11:0] VS_END   = 12'(V_ACT + V_FP + V_SYNC);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic        lk_meta_r;
  logic        lk_s;
  logic [11:0] h_nxt_s;
  logic [11:0] v_nxt_s;
  logic        run_nxt_s;
  logic        de_nxt_s;
  logic        hs_nxt_s;
  logic        vs_nxt_s;
  logic        fs_nxt_s;

  // Two-flop synchroniser for the asynchronous lock flag; lk_s is the only copy used.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lk_meta_r <= 1'b0;
      lk_s      <= 1'b0;
    end else begin
      lk_meta_r <= pll_locked;
      lk_s      <= lk_meta_r;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state: follow the synchronised lock flag.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (lk_s) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (!lk_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Next counter values and decoded strobes. Everything is decoded from the
  // next counter values so the registered strobes line up with the
  // registered counters. Counting only advances RUN->RUN, so the first RUN
  // cycle (and every relock) starts at (0,0).
  always_comb begin
    h_nxt_s = 12'd0;
    v_nxt_s = 12'd0;
    if ((state_r == RUN) && (state_nxt_s == RUN)) begin
      if (hcnt == (HTOT - 12'd1)) begin
        h_nxt_s = 12'd0;
        if (vcnt == (VTOT - 12'd1)) begin
          v_nxt_s = 12'd0;
        end else begin
          v_nxt_s = vcnt + 12'd1;
        end
      end else begin
        h_nxt_s = hcnt + 12'd1;
        v_nxt_s = vcnt;
      end
    end else begin
      h_nxt_s = 12'd0;
      v_nxt_s = 12'd0;
    end

    run_nxt_s = (state_nxt_s == RUN);
    de_nxt_s  = run_nxt_s && (h_nxt_s < H_ACT_W) && (v_nxt_s < V_ACT_W);
    fs_nxt_s  = run_nxt_s && (h_nxt_s == 12'd0) && (v_nxt_s == 12'd0);
    if (run_nxt_s && (h_nxt_s >= HS_START) && (h_nxt_s < HS_END)) begin
      hs_nxt_s = H_POL;
    end else begin
      hs_nxt_s = ~H_POL;
    end
    if (run_nxt_s && (v_nxt_s >= VS_START) && (v_nxt_s < VS_END)) begin
      vs_nxt_s = V_POL;
    end else begin
      vs_nxt_s = ~V_POL;
    end
  end

  // Output registers; reset drives the IDLE values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt        <= 12'd0;
      vcnt        <= 12'd0;
      running     <= 1'b0;
      de          <= 1'b0;
      frame_start <= 1'b0;
      hs          <= ~H_POL;
      vs          <= ~V_POL;
    end else begin
      hcnt        <= h_nxt_s;
      vcnt        <= v_nxt_s;
      running     <= run_nxt_s;
      de          <= de_nxt_s;
      frame_start <= fs_nxt_s;
      hs          <= hs_nxt_s;
      vs          <= vs_nxt_s;
    end
  end

endmodule

// File: tb/tb_hdmi_video_timing.sv
// tb_hdmi_video_timing
// Directed bench for hdmi_video_timing. Three instances share clock, reset
// and lock: d uses the 720p defaults (lock-up, first-line boundaries),
// s uses a small raster (HTOT=28, VTOT=13) so whole frames and lock loss
// fit in a short run, and p is the small raster with inverted polarities.
// Small raster: hs on hcnt 20..22, de for hcnt<16 and vcnt<6, vs on lines 8..9.
module tb_hdmi_video_timing;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic pll_locked = 1'b0;
  int   compared = 0;
  int   mismatched = 0;

  logic d_hs, d_vs, d_de, d_fs, d_running;
  logic [11:0] d_hcnt, d_vcnt;
  logic s_hs, s_vs, s_de, s_fs, s_running;
  logic [11:0] s_hcnt, s_vcnt;
  logic p_hs, p_vs, p_de, p_fs, p_running;
  logic [11:0] p_hcnt, p_vcnt;

  always #5 clk = ~clk;

  hdmi_video_timing dut_d (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked),
    .hs(d_hs), .vs(d_vs), .de(d_de), .hcnt(d_hcnt), .vcnt(d_vcnt),
    .frame_start(d_fs), .running(d_running)
  );

  hdmi_video_timing #(
    .H_ACT(16), .H_FP(4), .H_SYNC(3), .H_BP(5),
    .V_ACT(6), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked),
    .hs(s_hs), .vs(s_vs), .de(s_de), .hcnt(s_hcnt), .vcnt(s_vcnt),
    .frame_start(s_fs), .running(s_running)
  );

  hdmi_video_timing #(
    .H_ACT(16), .H_FP(4), .H_SYNC(3), .H_BP(5),
    .V_ACT(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .H_POL(1'b0), .V_POL(1'b0)
  ) dut_p (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked),
    .hs(p_hs), .vs(p_vs), .de(p_de), .hcnt(p_hcnt), .vcnt(p_vcnt),
    .frame_start(p_fs), .running(p_running)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pll_locked = 1'b0;
    step();
    step();
    compared++;
    if ({d_running, d_fs, d_de, d_hs, d_vs, d_hcnt, d_vcnt} !== {5'b00000, 12'd0, 12'd0}) begin
      mismatched++;
      $display("FAIL reset_d got %h want %h", {d_running, d_fs, d_de, d_hs, d_vs, d_hcnt, d_vcnt}, 29'h0);
    end
    compared++;
    if ({p_running, p_fs, p_de, p_hs, p_vs} !== 5'b00011) begin
      mismatched++;
      $display("FAIL reset_p_pol got %b want 00011", {p_running, p_fs, p_de, p_hs, p_vs});
    end
    rst_n = 1'b1;
    step();
    step();
    step();
    compared++;
    if ({d_running, d_fs, d_de, d_hcnt, d_vcnt} !== {3'b000, 12'd0, 12'd0}) begin
      mismatched++;
      $display("FAIL idle_unlocked got run=%b fs=%b de=%b h=%0d v=%0d want all 0", d_running, d_fs, d_de, d_hcnt, d_vcnt);
    end
  endtask

  task automatic test_lockup();
    pll_locked = 1'b1;
    step();
    compared++;
    if (d_running !== 1'b0) begin
      mismatched++;
      $display("FAIL lockup_edge0 got running=%b want 0", d_running);
    end
    step();
    compared++;
    if (d_running !== 1'b0) begin
      mismatched++;
      $display("FAIL lockup_edge1 got running=%b want 0", d_running);
    end
    step();
    compared++;
    if ({d_running, d_fs, d_de, d_hs, d_vs, d_hcnt, d_vcnt} !== {5'b11100, 12'd0, 12'd0}) begin
      mismatched++;
      $display("FAIL lockup_edge2_d got %h want %h", {d_running, d_fs, d_de, d_hs, d_vs, d_hcnt, d_vcnt}, {5'b11100, 24'd0});
    end
    compared++;
    if ({s_running, s_fs, s_de, s_hcnt, s_vcnt} !== {3'b111, 12'd0, 12'd0}) begin
      mismatched++;
      $display("FAIL lockup_edge2_s got run=%b fs=%b de=%b h=%0d v=%0d want 1 1 1 0 0", s_running, s_fs, s_de, s_hcnt, s_vcnt);
    end
    compared++;
    if ({p_running, p_fs, p_de, p_hs, p_vs} !== 5'b11111) begin
      mismatched++;
      $display("FAIL lockup_edge2_p got %b want 11111", {p_running, p_fs, p_de, p_hs, p_vs});
    end
  endtask

  task automatic test_default_line();
    int de_cnt = 0;
    int hs_cnt = 0;
    int rise_at = -1;
    int fall_at = -1;
    logic prev_hs = 1'b0;
    for (int k = 0; k < 1650; k++) begin
      if (d_de === 1'b1) de_cnt++;
      if (d_hs === 1'b1) hs_cnt++;
      if ((d_hs === 1'b1) && (prev_hs === 1'b0) && (rise_at < 0)) rise_at = int'(d_hcnt);
      if ((d_hs === 1'b0) && (prev_hs === 1'b1) && (fall_at < 0)) fall_at = int'(d_hcnt);
      prev_hs = d_hs;
      if (k == 1279) begin
        compared++;
        if ({d_de, d_hcnt, d_vcnt} !== {1'b1, 12'd1279, 12'd0}) begin
          mismatched++;
          $display("FAIL de_last_active got de=%b h=%0d v=%0d want 1 1279 0", d_de, d_hcnt, d_vcnt);
        end
      end
      if (k == 1280) begin
        compared++;
        if ({d_de, d_hcnt} !== {1'b0, 12'd1280}) begin
          mismatched++;
          $display("FAIL de_first_blank got de=%b h=%0d want 0 1280", d_de, d_hcnt);
        end
      end
      if (k == 1649) begin
        compared++;
        if ({d_hcnt, d_vcnt, d_hs} !== {12'd1649, 12'd0, 1'b0}) begin
          mismatched++;
          $display("FAIL line_end got h=%0d v=%0d hs=%b want 1649 0 0", d_hcnt, d_vcnt, d_hs);
        end
      end
      step();
    end
    compared++;
    if ({d_hcnt, d_vcnt, d_fs, d_de} !== {12'd0, 12'd1, 1'b0, 1'b1}) begin
      mismatched++;
      $display("FAIL line_wrap got h=%0d v=%0d fs=%b de=%b want 0 1 0 1", d_hcnt, d_vcnt, d_fs, d_de);
    end
    compared++;
    if (de_cnt != 1280) begin
      mismatched++;
      $display("FAIL line_de_count got %0d want 1280", de_cnt);
    end
    compared++;
    if (hs_cnt != 40) begin
      mismatched++;
      $display("FAIL line_hs_width got %0d want 40", hs_cnt);
    end
    compared++;
    if ((rise_at != 1390) || (fall_at != 1430)) begin
      mismatched++;
      $display("FAIL hs_edges got rise=%0d fall=%0d want 1390 1430", rise_at, fall_at);
    end
  endtask

  task automatic test_lock_loss();
    int waited = 0;
    while (!((s_hcnt == 12'd10) && (s_vcnt == 12'd5)) && (waited < 400)) begin
      step();
      waited++;
    end
    compared++;
    if (waited >= 400) begin
      mismatched++;
      $display("FAIL lockloss_reach got h=%0d v=%0d want 10 5 within 400 cycles", s_hcnt, s_vcnt);
    end
    pll_locked = 1'b0;
    step();
    compared++;
    if ({s_running, s_hcnt, s_vcnt} !== {1'b1, 12'd11, 12'd5}) begin
      mismatched++;
      $display("FAIL lockloss_c1 got run=%b h=%0d v=%0d want 1 11 5", s_running, s_hcnt, s_vcnt);
    end
    step();
    compared++;
    if ({s_running, s_hcnt, s_vcnt} !== {1'b1, 12'd12, 12'd5}) begin
      mismatched++;
      $display("FAIL lockloss_c2 got run=%b h=%0d v=%0d want 1 12 5", s_running, s_hcnt, s_vcnt);
    end
    step();
    compared++;
    if ({s_running, s_fs, s_de, s_hs, s_vs, s_hcnt, s_vcnt} !== {5'b00000, 12'd0, 12'd0}) begin
      mismatched++;
      $display("FAIL lockloss_idle got %h want 0", {s_running, s_fs, s_de, s_hs, s_vs, s_hcnt, s_vcnt});
    end
    compared++;
    if ({p_running, p_hs, p_vs} !== 3'b011) begin
      mismatched++;
      $display("FAIL lockloss_p_idle got %b want 011", {p_running, p_hs, p_vs});
    end
    pll_locked = 1'b1;
    step();
    step();
    compared++;
    if (s_running !== 1'b0) begin
      mismatched++;
      $display("FAIL relock_edge1 got running=%b want 0", s_running);
    end
    step();
    compared++;
    if ({s_running, s_fs, s_de, s_hcnt, s_vcnt} !== {3'b111, 12'd0, 12'd0}) begin
      mismatched++;
      $display("FAIL relock_restart got run=%b fs=%b de=%b h=%0d v=%0d want 1 1 1 0 0", s_running, s_fs, s_de, s_hcnt, s_vcnt);
    end
  endtask

  task automatic test_small_frame();
    int de_cnt = 0;
    int hs_cnt = 0;
    int hs_rises = 0;
    int vs_cnt = 0;
    int vs_rises = 0;
    int fs_cnt = 0;
    int p_hs_low = 0;
    int p_vs_low = 0;
    int p_disagree = 0;
    int hs_rise_h = -1;
    logic prev_hs = 1'b0;
    logic prev_vs = 1'b0;
    for (int i = 0; i < 364; i++) begin
      if (s_de === 1'b1) de_cnt++;
      if (s_hs === 1'b1) hs_cnt++;
      if (s_vs === 1'b1) vs_cnt++;
      if (s_fs === 1'b1) fs_cnt++;
      if (p_hs === 1'b0) p_hs_low++;
      if (p_vs === 1'b0) p_vs_low++;
      if ((p_hs !== ~s_hs) || (p_vs !== ~s_vs)) p_disagree++;
      if ((s_hs === 1'b1) && (prev_hs === 1'b0)) begin
        hs_rises++;
        if (hs_rise_h < 0) hs_rise_h = int'(s_hcnt);
      end
      if ((s_vs === 1'b1) && (prev_vs === 1'b0)) begin
        vs_rises++;
        compared++;
        if ({s_hcnt, s_vcnt} !== {12'd0, 12'd8}) begin
          mismatched++;
          $display("FAIL vs_rise_pos got h=%0d v=%0d want 0 8", s_hcnt, s_vcnt);
        end
      end
      prev_hs = s_hs;
      prev_vs = s_vs;
      if (i == 363) begin
        compared++;
        if ({s_hcnt, s_vcnt, s_fs} !== {12'd27, 12'd12, 1'b0}) begin
          mismatched++;
          $display("FAIL frame_last got h=%0d v=%0d fs=%b want 27 12 0", s_hcnt, s_vcnt, s_fs);
        end
      end
      step();
    end
    compared++;
    if ({s_fs, s_hcnt, s_vcnt} !== {1'b1, 12'd0, 12'd0}) begin
      mismatched++;
      $display("FAIL frame_wrap got fs=%b h=%0d v=%0d want 1 0 0", s_fs, s_hcnt, s_vcnt);
    end
    compared++;
    if (de_cnt != 96) begin
      mismatched++;
      $display("FAIL frame_de_count got %0d want 96", de_cnt);
    end
    compared++;
    if ((hs_cnt != 39) || (hs_rises != 13) || (hs_rise_h != 20)) begin
      mismatched++;
      $display("FAIL frame_hs got cycles=%0d pulses=%0d rise_h=%0d want 39 13 20", hs_cnt, hs_rises, hs_rise_h);
    end
    compared++;
    if ((vs_cnt != 56) || (vs_rises != 1)) begin
      mismatched++;
      $display("FAIL frame_vs got cycles=%0d pulses=%0d want 56 1", vs_cnt, vs_rises);
    end
    compared++;
    if (fs_cnt != 1) begin
      mismatched++;
      $display("FAIL frame_start_count got %0d want 1", fs_cnt);
    end
    compared++;
    if ((p_hs_low != 39) || (p_vs_low != 56) || (p_disagree != 0)) begin
      mismatched++;
      $display("FAIL polarity got hs_low=%0d vs_low=%0d disagree=%0d want 39 56 0", p_hs_low, p_vs_low, p_disagree);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) step();
    #3;
    rst_n = 1'b0;
    #1;
    compared++;
    if ({d_running, d_fs, d_de, d_hs, d_vs, d_hcnt, d_vcnt} !== {5'b00000, 12'd0, 12'd0}) begin
      mismatched++;
      $display("FAIL async_reset_d got %h want 0", {d_running, d_fs, d_de, d_hs, d_vs, d_hcnt, d_vcnt});
    end
    compared++;
    if ({p_running, p_hs, p_vs} !== 3'b011) begin
      mismatched++;
      $display("FAIL async_reset_p got %b want 011", {p_running, p_hs, p_vs});
    end
    #1;
    rst_n = 1'b1;
    step();
    compared++;
    if (d_running !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_release_edge0 got running=%b want 0", d_running);
    end
    step();
    compared++;
    if (d_running !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_release_edge1 got running=%b want 0", d_running);
    end
    step();
    compared++;
    if ({d_running, d_fs, d_de, d_hcnt, d_vcnt} !== {3'b111, 12'd0, 12'd0}) begin
      mismatched++;
      $display("FAIL rst_release_edge2 got run=%b fs=%b de=%b h=%0d v=%0d want 1 1 1 0 0", d_running, d_fs, d_de, d_hcnt, d_vcnt);
    end
  endtask

  initial begin
    test_reset();
    test_lockup();
    test_default_line();
    test_lock_loss();
    test_small_frame();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
